output_drain_fifo: RTL and testbench

// - Downstream of the conv controller/datapath: captures each finished output tuple (data, x, y, ch) on

---
 rtl/output_drain_fifo_if.sv | 47 ++++
 rtl/output_drain_fifo.sv | 137 +++++++++++++
 tb/tb_output_drain_fifo.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/output_drain_fifo_if.sv
// Handshake bundle between the conv controller/datapath, the output drain FIFO and the consumer.
//   slave  : the FIFO side (takes the in_* tuple stream and flush, drives out_* and status)
//   master : the environment side (drives the in_* tuple stream, flush and out_ready)
// Signals:
//   in_valid/in_data/in_x/in_y/in_ch  finished output tuple from the controller/datapath
//   stall_upstream                    controller must stop issuing MACs
//   out_valid/out_ready               consumer handshake on the head entry
//   out_data/out_x/out_y/out_ch       head entry contents
//   level                             occupancy, 0..DEPTH
//   overflow_err                      sticky: a write was dropped
//   frame_done                        one-cycle pulse after the last tuple of a frame drains
//   flush                             synchronous clear
interface output_drain_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
);
    localparam int unsigned LvlW = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic [31:0]           in_x;
    logic [31:0]           in_y;
    logic [31:0]           in_ch;
    logic                  stall_upstream;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [31:0]           out_x;
    logic [31:0]           out_y;
    logic [31:0]           out_ch;
    logic [LvlW-1:0]       level;
    logic                  overflow_err;
    logic                  frame_done;
    logic                  flush;

    modport slave (
        input  in_valid, in_data, in_x, in_y, in_ch, out_ready, flush,
        output stall_upstream, out_valid, out_data, out_x, out_y, out_ch,
        output level, overflow_err, frame_done
    );

    modport master (
        output in_valid, in_data, in_x, in_y, in_ch, out_ready, flush,
        input  stall_upstream, out_valid, out_data, out_x, out_y, out_ch,
        input  level, overflow_err, frame_done
    );
endinterface

// File: rtl/output_drain_fifo.sv
// Output drain FIFO: captures finished (data, x, y, ch) tuples from the conv controller/datapath
// and drains them to the consumer over valid/ready, first-word-fall-through.
// Ports:
//   clk        clock
//   arst_n_in  asynchronous active-low reset
//   bus        output_drain_fifo_if.slave (tuple input, consumer handshake, status, flush)
// stall_upstream asserts while fewer than ALMOST_FULL_MARGIN slots are free, leaving room for
// results still in the MAC pipeline. overflow_err is sticky until flush or reset.
// Optional feature: define OUTPUT_RELU_EN to clamp negative data words to zero on write.
module output_drain_fifo #(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned DEPTH              = 8,
    parameter int unsigned ALMOST_FULL_MARGIN = 6,
    parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
    parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
    parameter int unsigned OUTPUT_NB_CHANNELS = 64
) (
    input  logic                     clk,
    input  logic                     arst_n_in,
    output_drain_fifo_if.slave       bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    localparam logic [LvlW-1:0] DepthLvl  = LvlW'(DEPTH);
    localparam logic [LvlW-1:0] MarginLvl = LvlW'(ALMOST_FULL_MARGIN);
    localparam logic [31:0]     LastX     = 32'(FEATURE_MAP_WIDTH - 1);
    localparam logic [31:0]     LastY     = 32'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [31:0]     LastCh    = 32'(OUTPUT_NB_CHANNELS - 1);

    // Storage, intentionally not reset.
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [31:0]           x_mem    [DEPTH];
    logic [31:0]           y_mem    [DEPTH];
    logic [31:0]           ch_mem   [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic            overflow_q, overflow_d;
    logic            frame_done_q, frame_done_d;

    logic                  not_empty;
    logic                  rd_en;
    logic                  wr_en;
    logic                  mem_we;
    logic                  head_last;
    logic [DATA_WIDTH-1:0] wr_data;

    always_comb begin
        not_empty = (level_q != '0);
        rd_en     = not_empty && bus.out_ready;
        // A full FIFO still accepts when the head leaves in the same cycle.
        wr_en     = bus.in_valid && ((level_q < DepthLvl) || rd_en);
        mem_we    = wr_en && !bus.flush;
        head_last = (x_mem[rd_ptr_q] == LastX) && (y_mem[rd_ptr_q] == LastY) &&
                    (ch_mem[rd_ptr_q] == LastCh);
    end

`ifdef OUTPUT_RELU_EN
    always_comb begin
        wr_data = bus.in_data[DATA_WIDTH-1] ? '0 : bus.in_data;
    end
`else
    always_comb begin
        wr_data = bus.in_data;
    end
`endif

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;

        if (bus.flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (rd_en) begin
                rd_ptr_d     = rd_ptr_q + PtrW'(1);
                frame_done_d = head_last;
            end
            unique case ({wr_en, rd_en})
                2'b10:   level_d = level_q + LvlW'(1);
                2'b01:   level_d = level_q - LvlW'(1);
                default: level_d = level_q;
            endcase
            if (bus.in_valid && !wr_en) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            data_mem[wr_ptr_q] <= wr_data;
            x_mem[wr_ptr_q]    <= bus.in_x;
            y_mem[wr_ptr_q]    <= bus.in_y;
            ch_mem[wr_ptr_q]   <= bus.in_ch;
        end
    end

    always_comb begin
        bus.out_valid      = not_empty;
        bus.out_data       = data_mem[rd_ptr_q];
        bus.out_x          = x_mem[rd_ptr_q];
        bus.out_y          = y_mem[rd_ptr_q];
        bus.out_ch         = ch_mem[rd_ptr_q];
        bus.level          = level_q;
        bus.stall_upstream = (DepthLvl - level_q) < MarginLvl;
        bus.overflow_err   = overflow_q;
        bus.frame_done     = frame_done_q;
    end
endmodule

// File: tb/tb_output_drain_fifo.sv
// Testbench for output_drain_fifo: directed scenarios followed by randomized traffic, all checked
// against a queue-based reference model of the FIFO's observable behaviour.
module tb_output_drain_fifo;
    localparam int unsigned DataW  = 32;
    localparam int unsigned Depth  = 8;
    localparam int unsigned Margin = 6;

    typedef struct {
        logic [31:0] data;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] ch;
    } tuple_t;

    logic clk;
    logic arst_n_in;

    output_drain_fifo_if #(.DATA_WIDTH(DataW), .DEPTH(Depth)) ifc ();

    output_drain_fifo #(
        .DATA_WIDTH(DataW),
        .DEPTH(Depth),
        .ALMOST_FULL_MARGIN(Margin),
        .FEATURE_MAP_WIDTH(1024),
        .FEATURE_MAP_HEIGHT(1024),
        .OUTPUT_NB_CHANNELS(64)
    ) u_dut (
        .clk(clk),
        .arst_n_in(arst_n_in),
        .bus(ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     tests_run;
    int     fail_cnt;
    tuple_t model_q[$];
    logic   exp_ovf;
    logic   exp_fd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] stored_data(input logic [31:0] d);
`ifdef OUTPUT_RELU_EN
        return ($signed(d) < 0) ? 32'd0 : d;
`else
        return d;
`endif
    endfunction

    task automatic check_outputs();
        int n;
        n = model_q.size();
        check("level", 64'(ifc.level), 64'(n));
        check("out_valid", 64'(ifc.out_valid), 64'(n != 0));
        check("stall", 64'(ifc.stall_upstream), 64'((Depth - n) < Margin));
        check("overflow", 64'(ifc.overflow_err), 64'(exp_ovf));
        check("frame_done", 64'(ifc.frame_done), 64'(exp_fd));
        if (n != 0) begin
            check("out_data", 64'(ifc.out_data), 64'(model_q[0].data));
            check("out_x", 64'(ifc.out_x), 64'(model_q[0].x));
            check("out_y", 64'(ifc.out_y), 64'(model_q[0].y));
            check("out_ch", 64'(ifc.out_ch), 64'(model_q[0].ch));
        end
    endtask

    // Called at a negedge: drive one cycle of inputs, advance the model, check after the posedge.
    task automatic step(input logic v, input logic [31:0] d, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ch, input logic rdy,
                        input logic fl);
        bit     rd;
        bit     wr;
        tuple_t t;
        ifc.in_valid  = v;
        ifc.in_data   = d;
        ifc.in_x      = x;
        ifc.in_y      = y;
        ifc.in_ch     = ch;
        ifc.out_ready = rdy;
        ifc.flush     = fl;
        rd = (model_q.size() != 0) && rdy;
        wr = v && ((model_q.size() < Depth) || rd);
        if (fl) begin
            model_q.delete();
            exp_ovf = 1'b0;
            exp_fd  = 1'b0;
        end else begin
            exp_fd = rd && (model_q[0].x == 1023) && (model_q[0].y == 1023) &&
                     (model_q[0].ch == 63);
            if (rd) void'(model_q.pop_front());
            if (wr) begin
                t.data = stored_data(d);
                t.x    = x;
                t.y    = y;
                t.ch   = ch;
                model_q.push_back(t);
            end
            if (v && !wr) exp_ovf = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        ifc.flush     = 1'b0;
        #2 arst_n_in = 1'b0;
        model_q.delete();
        exp_ovf = 1'b0;
        exp_fd  = 1'b0;
        #1 check_outputs();
        @(negedge clk);
        arst_n_in = 1'b1;
        check_outputs();
    endtask

    function automatic logic [31:0] rand_coord(input int unsigned last);
        return ($urandom_range(3) == 0) ? 32'(last) : 32'($urandom_range(last));
    endfunction

    initial begin
        tests_run = 0;
        fail_cnt  = 0;
        exp_ovf   = 1'b0;
        exp_fd    = 1'b0;
        arst_n_in = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.in_data  = '0;
        ifc.in_x     = '0;
        ifc.in_y     = '0;
        ifc.in_ch    = '0;
        ifc.out_ready = 1'b0;
        ifc.flush    = 1'b0;
        @(negedge clk);
        do_reset();

        // Single tuple, consumer ready.
        step(1'b1, 32'h7, 32'd2, 32'd3, 32'd4, 1'b1, 1'b0);
        idle(1'b1);

        // Back-pressure: stall threshold around level 3 / 2.
        for (int i = 0; i < 3; i++) step(1'b1, 32'(100 + i), 32'(i), 32'd0, 32'd0, 1'b0, 1'b0);
        idle(1'b1);

        // Fill up and overflow.
        for (int i = 0; i < 8; i++) step(1'b1, 32'(200 + i), 32'(i), 32'd1, 32'd1, 1'b0, 1'b0);
        idle(1'b0);

        // Full with simultaneous read and write, then drain.
        step(1'b1, 32'h55, 32'd9, 32'd9, 32'd9, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) idle(1'b1);

        // End-of-frame detection.
        step(1'b1, 32'h1, 32'd1023, 32'd1023, 32'd62, 1'b0, 1'b0);
        step(1'b1, 32'h2, 32'd1023, 32'd1023, 32'd63, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Sign handling of the data word.
        step(1'b1, 32'hFFFF_FFF0, 32'd5, 32'd5, 32'd5, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0010, 32'd6, 32'd6, 32'd6, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Flush at level 5, with a write in the same cycle.
        for (int i = 0; i < 5; i++) step(1'b1, 32'(300 + i), 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h99, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        idle(1'b1);

        // Mid-stream asynchronous reset.
        for (int i = 0; i < 4; i++) step(1'b1, 32'(400 + i), 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(99) < 60), $urandom(), rand_coord(1023), rand_coord(1023),
                     rand_coord(63), 1'($urandom_range(99) < 45), 1'($urandom_range(99) < 2));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end
endmodule
